// File: rtl/upa1_ctl_if.sv
// Sample-strobe / coefficient bus between the a1 update controller and its environment (LIMD, sequencer).
interface upa1_ctl_if;
  logic        start;
  logic        PK0;
  logic        SIGPK;
  logic        TR;
  logic [15:0] A2P;
  logic [15:0] A1P;
  logic [15:0] A1T;
  logic [15:0] A1;
  logic        busy;
  logic        done;

  modport master (
    output start, PK0, SIGPK, TR, A2P, A1P,
    input  A1T, A1, busy, done
  );

  modport slave (
    input  start, PK0, SIGPK, TR, A2P, A1P,
    output A1T, A1, busy, done
  );
endinterface

// File: rtl/upa1_ctl.sv
// ADPCM second-order predictor a1 coefficient update controller.
// Optional macro A1_INTERNAL_LIMIT_EN: clamp A1T locally against A2P instead of using the external LIMD A1P.
module upa1_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4,
  upa1_ctl_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] a1_q, a1_d;
  logic [15:0] a1t_q, a1t_d;
  logic        pk1_q, pk1_d;
  logic        tr_q, tr_d;

  logic        pks;
  logic [15:0] uga1;
  logic [15:0] a1_shr;
  logic [15:0] a1t_calc;
  logic [15:0] a1_lim;
  logic        unused_dft;

  assign pks      = bus.PK0 ^ pk1_q;
  assign uga1     = bus.SIGPK ? 16'h0000 : (pks ? 16'hFF40 : 16'h00C0);
  assign a1_shr   = 16'($signed(a1_q) >>> 8);
  assign a1t_calc = a1_q + uga1 - a1_shr;

`ifdef A1_INTERNAL_LIMIT_EN
  logic [15:0] a1ul, a1ll;

  assign a1ul = 16'h3C00 - bus.A2P;
  assign a1ll = 16'h0000 - a1ul;

  always_comb begin
    a1_lim = a1t_q;
    if ($signed(a1t_q) > $signed(a1ul))
      a1_lim = a1ul;
    else if ($signed(a1t_q) < $signed(a1ll))
      a1_lim = a1ll;
  end

  assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                        scan_enable, test_mode, bus.A1P};
`else
  assign a1_lim     = bus.A1P;
  assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                        scan_enable, test_mode, bus.A2P};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a1_q    <= '0;
      a1t_q   <= '0;
      pk1_q   <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      a1t_q   <= a1t_d;
      pk1_q   <= pk1_d;
      tr_q    <= tr_d;
    end
  end

  // DONE also accepts start so a held strobe restarts on the cycle the done pulse ends.
  always_comb begin
    state_d = state_q;
    a1_d    = a1_q;
    a1t_d   = a1t_q;
    pk1_d   = pk1_q;
    tr_d    = tr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          tr_d    = bus.TR;
          a1t_d   = a1t_calc;
          pk1_d   = bus.PK0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef A1_INTERNAL_LIMIT_EN
      S_CALC: begin
        a1_d    = tr_q ? '0 : a1_lim;
        state_d = S_DONE;
      end
`else
      S_CALC: state_d = S_WAIT;
      S_WAIT: begin
        a1_d    = tr_q ? '0 : a1_lim;
        state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.A1T  = a1t_q;
  assign bus.A1   = a1_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

endmodule

// File: tb/tb_upa1_ctl.sv
// Self-checking bench for upa1_ctl: transaction-level reference model, external LIMD stand-in, directed and random stimulus.
module tb_upa1_ctl;
`ifdef A1_INTERNAL_LIMIT_EN
  localparam int P = 2;
`else
  localparam int P = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] scan_in;
  logic       scan_enable, test_mode;
  logic [4:0] scan_out;

  upa1_ctl_if bus();

  upa1_ctl dut (
    .clk        (clk),
    .reset      (reset),
    .scan_in0   (scan_in[0]),
    .scan_in1   (scan_in[1]),
    .scan_in2   (scan_in[2]),
    .scan_in3   (scan_in[3]),
    .scan_in4   (scan_in[4]),
    .scan_enable(scan_enable),
    .test_mode  (test_mode),
    .scan_out0  (scan_out[0]),
    .scan_out1  (scan_out[1]),
    .scan_out2  (scan_out[2]),
    .scan_out3  (scan_out[3]),
    .scan_out4  (scan_out[4]),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] limd(input logic [15:0] a1t, input logic [15:0] a2p);
    int ul, ll, v;
    ul = int'($signed(16'(16'h3C00 - a2p)));
    ll = int'($signed(16'(16'h0000 - 16'(16'h3C00 - a2p))));
    v  = int'($signed(a1t));
    if (v > ul) v = ul;
    else if (v < ll) v = ll;
    return 16'(v);
  endfunction

  function automatic logic [15:0] next_a1t(input logic [15:0] a1, input logic pks, input logic sg);
    int a, g;
    a = int'($signed(a1));
    g = sg ? 0 : (pks ? -192 : 192);
    return 16'(a + g - (a >>> 8));
  endfunction

  // Reference model: ph counts cycles since the accepted start (0 = idle, P = done cycle).
  logic [15:0] m_a1, m_a1t, m_lim;
  logic        m_pk1, m_tr;
  int          ph;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a1 = '0; m_a1t = '0; m_lim = '0; m_pk1 = 1'b0; m_tr = 1'b0; ph = 0;
    end else begin
      if (ph == 1) m_lim = limd(m_a1t, bus.A2P);
      if (ph == P - 1) m_a1 = m_tr ? 16'h0000 : m_lim;
      if ((ph == 0 || ph == P) && bus.start) begin
        m_a1t = next_a1t(m_a1, bus.PK0 ^ m_pk1, bus.SIGPK);
        m_pk1 = bus.PK0;
        m_tr  = bus.TR;
        ph    = 1;
      end else if (ph == P) ph = 0;
      else if (ph != 0) ph++;
    end
  end

  // Stand-in for the external LIMD register (ignored by the internal-limit build).
  always @(posedge clk) begin
`ifdef A1_INTERNAL_LIMIT_EN
    bus.A1P <= 16'($urandom);
`else
    bus.A1P <= limd(bus.A1T, bus.A2P);
`endif
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("A1T",  bus.A1T, m_a1t);
      check("A1",   bus.A1,  m_a1);
      check("busy", {15'b0, bus.busy}, {15'b0, ph != 0});
      check("done", {15'b0, bus.done}, {15'b0, ph == P});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic pk0, input logic sg, input logic tr,
                        input logic [15:0] a2p);
    bus.start = s; bus.PK0 = pk0; bus.SIGPK = sg; bus.TR = tr; bus.A2P = a2p;
  endtask

  task automatic update(input logic pk0, input logic sg, input logic tr,
                        input logic [15:0] a2p, output logic [15:0] a1t_e0);
    int n;
    set_in(1'b1, pk0, sg, tr, a2p);
    tick();
    a1t_e0 = bus.A1T;
    bus.start = 1'b0; bus.PK0 = ~pk0; bus.SIGPK = ~sg; bus.TR = ~tr;
    n = 0;
    while (!bus.done && n < 8) begin
      tick();
      n++;
    end
    check("done_seen", {15'b0, bus.done}, 16'h0001);
    tick();
    check("done_one_cycle", {15'b0, bus.done}, 16'h0000);
  endtask

  initial begin
    logic [15:0] v;
    logic        pk;
    int          dq[$];
    int          n;

    scan_in = 5'(($urandom)); scan_enable = 1'b0; test_mode = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_A1",   bus.A1,  16'h0000);
    check("rst_A1T",  bus.A1T, 16'h0000);
    check("rst_busy", {15'b0, bus.busy}, 16'h0000);
    check("rst_done", {15'b0, bus.done}, 16'h0000);
    check("rst_scan", {11'b0, scan_out}, 16'h0000);

    update(1'b0, 1'b0, 1'b0, 16'h0000, v);
    check("s1_A1T", v, 16'h00C0);
    check("s1_A1",  bus.A1, 16'h00C0);

    for (int i = 0; i < 200 && bus.A1 != 16'h3C00; i++) update(1'b0, 1'b0, 1'b0, 16'h0000, v);
    check("pos_pre_A1", bus.A1, 16'h3C00);
    update(1'b0, 1'b0, 1'b0, 16'h0000, v);
    check("pos_A1T", v, 16'h3C84);
    check("pos_A1",  bus.A1, 16'h3C00);

    update(1'b0, 1'b0, 1'b0, 16'h29CC, v);
    check("tr_pre_A1", bus.A1, 16'h1234);
    update(1'b0, 1'b0, 1'b1, 16'h0000, v);
    check("tr_A1T", v, 16'h12E2);
    check("tr_A1",  bus.A1, 16'h0000);

    update(1'b0, 1'b0, 1'b0, 16'h0000, v);
    update(1'b0, 1'b0, 1'b0, 16'h3B00, v);
    check("sig_pre_A1", bus.A1, 16'h0100);
    update(1'b0, 1'b1, 1'b0, 16'h0000, v);
    check("sig_A1T", v, 16'h00FF);

    pk = 1'b1;
    for (int i = 0; i < 300 && bus.A1 != 16'hC400; i++) begin
      update(pk, 1'b0, 1'b0, 16'h0000, v);
      pk = ~pk;
    end
    check("neg_pre_A1", bus.A1, 16'hC400);
    update(pk, 1'b0, 1'b0, 16'h0000, v);
    check("neg_A1T", v, 16'hC37C);
    check("neg_A1",  bus.A1, 16'hC400);

    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done) dq.push_back(c);
    end
    check("b2b_count_ge3", {15'b0, dq.size() >= 3}, 16'h0001);
    if (dq.size() >= 3) begin
      check("b2b_gap1", 16'(dq[1] - dq[0]), 16'(P));
      check("b2b_gap2", 16'(dq[2] - dq[1]), 16'(P));
    end
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 8) begin
      tick();
      n++;
    end
    check("b2b_idle", {15'b0, bus.busy}, 16'h0000);

    set_in(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    bus.start = 1'b0;
    if (P == 3) tick();
    check("abort_pre_busy", {15'b0, bus.busy}, 16'h0001);
    reset = 1'b1;
    tick();
    check("abort_A1",   bus.A1, 16'h0000);
    check("abort_done", {15'b0, bus.done}, 16'h0000);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_no_done", {15'b0, bus.done}, 16'h0000);
    end

    update(1'b0, 1'b0, 1'b0, 16'h0000, v);
    check("fresh_A1T", v, 16'h00C0);
    check("fresh_A1",  bus.A1, 16'h00C0);

    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      bus.start   = $urandom_range(0, 1) == 1;
      bus.PK0     = $urandom_range(0, 1) == 1;
      bus.SIGPK   = $urandom_range(0, 3) == 0;
      bus.TR      = $urandom_range(0, 9) == 0;
      bus.A2P     = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h3000));
      scan_in     = 5'($urandom);
      scan_enable = $urandom_range(0, 1) == 1;
      test_mode   = $urandom_range(0, 1) == 1;
      tick();
    end
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
